trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter RST_PC, default 32'h0, meaning the value driven on int_addr_o while idle and after reset.
REQ-002 SHALL have port clk  input  1  system clock; single clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port irq_i  input  1  external interrupt request, level-sensitive.
REQ-005 SHALL have port ecall_i / ebreak_i / mret_i  input  1 each  single-cycle decode pulses from the execute stage.
REQ-006 SHALL have port inst_addr_i  input  `CPU_WIDTH  PC of the instruction in execute.
REQ-007 SHALL have port jump_flag_i  input  1  execute-stage jump taken; jump_addr_i  input  `CPU_WIDTH  jump target.
REQ-008 SHALL have ports csr_mtvec_i, csr_mepc_i, csr_mstatus_i  input  `CPU_WIDTH  current values from the CSR register file.
REQ-009 SHALL have ports csr_wr_en_o  output  1; csr_wr_addr_o  output  `CSR_ADDR_WIDTH; csr_wr_data_o  output  `CPU_WIDTH, driving the CSR file's priority (client) write port.
REQ-010 SHALL have port hold_flag_o  output  1  pipeline stall request.
REQ-011 SHALL have ports int_assert_o  output  1  PC redirect pulse; int_addr_o  output  `CPU_WIDTH  redirect target.

Function
REQ-012 SHALL implement FSM states IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, JUMP, MRET_MSTATUS, MRET_JUMP.
REQ-013 In IDLE, event priority SHALL be ecall_i > ebreak_i > mret_i > (irq_i AND csr_mstatus_i[3]); lower events in the same cycle are dropped, except irq, which stays pending because it is a level.
REQ-014 On ecall/ebreak: latch mepc = inst_addr_i and cause = 32'd11 or 32'd3; next state W_MEPC.
REQ-015 On an accepted irq: latch mepc = jump_addr_i if jump_flag_i, else inst_addr_i; cause = 32'h8000_000B; next state W_MEPC.
REQ-016 W_MEPC SHALL write `CSR_MEPC with the latched mepc, then go to W_MSTATUS.
REQ-017 W_MSTATUS SHALL write `CSR_MSTATUS with csr_mstatus_i, with bit7 (MPIE) set to old bit3 and bit3 (MIE) cleared, then go to W_MCAUSE.
REQ-018 W_MCAUSE SHALL write `CSR_MCAUSE with the latched cause, then go to JUMP.
REQ-019 JUMP SHALL assert int_assert_o for exactly one cycle with int_addr_o = csr_mtvec_i, then return to IDLE.
REQ-020 On mret: MRET_MSTATUS SHALL write `CSR_MSTATUS with bit3 set to old bit7 and bit7 set to 1; MRET_JUMP SHALL then pulse int_assert_o with int_addr_o = csr_mepc_i, then return to IDLE.
REQ-021 csr_wr_en_o SHALL be high only in the W_* and MRET_MSTATUS states; outside those states, addr and data SHALL be 0.
REQ-022 hold_flag_o SHALL be combinationally high in the event-accept cycle and in every non-IDLE state. Trap latency, event to int_assert_o, is 4 cycles; mret latency is 2 cycles.
REQ-023 Events arriving in a non-IDLE state SHALL be ignored.
REQ-024 int_addr_o SHALL equal RST_PC whenever int_assert_o is low.

Reset
REQ-025 While rst=1 at a clk edge: state SHALL be IDLE and latched mepc/cause SHALL be 0; outputs SHALL be csr_wr_en_o=0, addr=0, data=0, hold_flag_o=0, int_assert_o=0, int_addr_o=RST_PC.
REQ-026 Reset mid-sequence SHALL abandon the sequence with no further CSR writes. CSR writes already issued SHALL stand.

Structure
REQ-027 `CSR_MEPC/`CSR_MSTATUS/`CSR_MCAUSE/`CSR_MTVEC, the cause codes (ECALL=11, EBREAK=3, MEXT_INT=32'h8000_000B), the MIE/MPIE bit indices and the FSM state encodings SHALL reside in the shared defines file.
REQ-028 The block SHALL be a single module with no sub-modules. State and latches SHALL be registered; outputs SHALL be decoded from state.

Verification
REQ-029 ecall_i at PC 0x100, mtvec=0x200, mstatus=0x8 -> writes MEPC=0x100, MSTATUS=0x80, MCAUSE=11 on consecutive cycles; int_assert_o with 0x200 at cycle 4; hold high for cycles 0-4.
REQ-030 irq_i=1 with mstatus=0x8, jump_flag_i=1, jump_addr_i=0x340 -> MEPC=0x340, MCAUSE=0x8000000B.
REQ-031 irq_i=1 with mstatus=0x0 -> no writes, hold_flag_o=0; raising MIE -> trap is taken on the next cycle.
REQ-032 mret_i with mstatus=0x80, mepc=0x104 -> MSTATUS=0x88 written, then int_assert_o with 0x104; total 2 cycles.
REQ-033 ecall_i, mret_i and irq_i in the same cycle -> only the ecall sequence runs; irq_i held high -> taken after return to IDLE.
REQ-034 rst asserted during W_MSTATUS -> next cycle IDLE, all outputs at reset values, no MCAUSE write.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg -- shared definitions for the trap controller.
//   CPU_WIDTH / CSR_ADDR_WIDTH : datapath and CSR address widths
//   CSR_*                      : machine-mode CSR addresses
//   CAUSE_*                    : mcause values written on trap entry
//   MIE_BIT / MPIE_BIT         : mstatus bit positions
//   trap_state_e               : FSM state encodings
//   trap_mstatus / mret_mstatus: mstatus rewrite on trap entry / return
package trap_ctrl_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int CSR_ADDR_WIDTH = 12;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE  = 12'h342;

  localparam logic [CPU_WIDTH-1:0] CAUSE_ECALL    = 32'd11;
  localparam logic [CPU_WIDTH-1:0] CAUSE_EBREAK   = 32'd3;
  localparam logic [CPU_WIDTH-1:0] CAUSE_MEXT_INT = 32'h8000_000B;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_W_MEPC       = 3'd1,
    ST_W_MSTATUS    = 3'd2,
    ST_W_MCAUSE     = 3'd3,
    ST_JUMP         = 3'd4,
    ST_MRET_MSTATUS = 3'd5,
    ST_MRET_JUMP    = 3'd6
  } trap_state_e;

  // Trap entry: save the interrupt enable into MPIE, then disable interrupts.
  function automatic logic [CPU_WIDTH-1:0] trap_mstatus(input logic [CPU_WIDTH-1:0] m);
    logic [CPU_WIDTH-1:0] r;
    r           = m;
    r[MPIE_BIT] = m[MIE_BIT];
    r[MIE_BIT]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and leave MPIE set.
  function automatic logic [CPU_WIDTH-1:0] mret_mstatus(input logic [CPU_WIDTH-1:0] m);
    logic [CPU_WIDTH-1:0] r;
    r           = m;
    r[MIE_BIT]  = m[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// trap_ctrl -- machine-mode trap sequencer.
// Accepts ecall / ebreak / mret / external interrupt in IDLE, then walks the
// CSR writes (mepc, mstatus, mcause) one per cycle before redirecting the PC
// to mtvec; mret rewrites mstatus and redirects to mepc.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   irq_i                          level-sensitive external interrupt
//   ecall_i, ebreak_i, mret_i      single-cycle decode pulses
//   inst_addr_i                    PC of the instruction in execute
//   jump_flag_i, jump_addr_i       execute-stage jump and its target
//   csr_mtvec_i/mepc_i/mstatus_i   current CSR values
//   csr_wr_en_o/addr_o/data_o      CSR priority write port
//   hold_flag_o                    pipeline stall request
//   int_assert_o, int_addr_o       PC redirect pulse and target
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RST_PC = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      irq_i,
  input  logic                      ecall_i,
  input  logic                      ebreak_i,
  input  logic                      mret_i,
  input  logic [CPU_WIDTH-1:0]      inst_addr_i,
  input  logic                      jump_flag_i,
  input  logic [CPU_WIDTH-1:0]      jump_addr_i,
  input  logic [CPU_WIDTH-1:0]      csr_mtvec_i,
  input  logic [CPU_WIDTH-1:0]      csr_mepc_i,
  input  logic [CPU_WIDTH-1:0]      csr_mstatus_i,
  output logic                      csr_wr_en_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_wr_addr_o,
  output logic [CPU_WIDTH-1:0]      csr_wr_data_o,
  output logic                      hold_flag_o,
  output logic                      int_assert_o,
  output logic [CPU_WIDTH-1:0]      int_addr_o
);

  trap_state_e          state_reg, state_next;
  logic [CPU_WIDTH-1:0] mepc_reg, mepc_next;
  logic [CPU_WIDTH-1:0] cause_reg, cause_next;
  logic                 irq_ok;
  logic                 event_any;

  // The interrupt is only visible while globally enabled; being a level it
  // simply reappears after a higher-priority sequence finishes.
  assign irq_ok    = irq_i & csr_mstatus_i[MIE_BIT];
  assign event_any = ecall_i | ebreak_i | mret_i | irq_ok;

  always_comb begin
    state_next = state_reg;
    mepc_next  = mepc_reg;
    cause_next = cause_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ecall_i) begin
          mepc_next  = inst_addr_i;
          cause_next = CAUSE_ECALL;
          state_next = ST_W_MEPC;
        end else if (ebreak_i) begin
          mepc_next  = inst_addr_i;
          cause_next = CAUSE_EBREAK;
          state_next = ST_W_MEPC;
        end else if (mret_i) begin
          state_next = ST_MRET_MSTATUS;
        end else if (irq_ok) begin
          // A taken jump in execute means the next instruction to run is the
          // jump target, so that is where the handler must return.
          mepc_next  = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_next = CAUSE_MEXT_INT;
          state_next = ST_W_MEPC;
        end
      end
      ST_W_MEPC:       state_next = ST_W_MSTATUS;
      ST_W_MSTATUS:    state_next = ST_W_MCAUSE;
      ST_W_MCAUSE:     state_next = ST_JUMP;
      ST_JUMP:         state_next = ST_IDLE;
      ST_MRET_MSTATUS: state_next = ST_MRET_JUMP;
      ST_MRET_JUMP:    state_next = ST_IDLE;
      default:         state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      mepc_reg  <= '0;
      cause_reg <= '0;
    end else begin
      state_reg <= state_next;
      mepc_reg  <= mepc_next;
      cause_reg <= cause_next;
    end
  end

  // Outputs are decoded from the current state. They are forced to their
  // idle values while reset is high so an abandoned sequence issues nothing.
  always_comb begin
    csr_wr_en_o   = 1'b0;
    csr_wr_addr_o = '0;
    csr_wr_data_o = '0;
    hold_flag_o   = 1'b0;
    int_assert_o  = 1'b0;
    int_addr_o    = RST_PC;
    if (!rst) begin
      case (state_reg)
        ST_IDLE: hold_flag_o = event_any;
        ST_W_MEPC: begin
          hold_flag_o   = 1'b1;
          csr_wr_en_o   = 1'b1;
          csr_wr_addr_o = CSR_MEPC;
          csr_wr_data_o = mepc_reg;
        end
        ST_W_MSTATUS: begin
          hold_flag_o   = 1'b1;
          csr_wr_en_o   = 1'b1;
          csr_wr_addr_o = CSR_MSTATUS;
          csr_wr_data_o = trap_mstatus(csr_mstatus_i);
        end
        ST_W_MCAUSE: begin
          hold_flag_o   = 1'b1;
          csr_wr_en_o   = 1'b1;
          csr_wr_addr_o = CSR_MCAUSE;
          csr_wr_data_o = cause_reg;
        end
        ST_JUMP: begin
          hold_flag_o  = 1'b1;
          int_assert_o = 1'b1;
          int_addr_o   = csr_mtvec_i;
        end
        ST_MRET_MSTATUS: begin
          hold_flag_o   = 1'b1;
          csr_wr_en_o   = 1'b1;
          csr_wr_addr_o = CSR_MSTATUS;
          csr_wr_data_o = mret_mstatus(csr_mstatus_i);
        end
        ST_MRET_JUMP: begin
          hold_flag_o  = 1'b1;
          int_assert_o = 1'b1;
          int_addr_o   = csr_mepc_i;
        end
        default: hold_flag_o = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl -- table-driven check of trap_ctrl: one vector per clock
// cycle plus hand-written latency sequences.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  localparam logic [31:0] RP    = 32'h0000_1000;
  localparam logic [31:0] MTVEC = 32'h0000_0200;
  localparam logic [11:0] A_MEPC = 12'h341;
  localparam logic [11:0] A_MST  = 12'h300;
  localparam logic [11:0] A_MCA  = 12'h342;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq_i = 1'b0, ecall_i = 1'b0, ebreak_i = 1'b0, mret_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic [31:0] csr_mtvec_i = MTVEC;
  logic [31:0] csr_mepc_i = '0;
  logic [31:0] csr_mstatus_i = '0;
  logic        csr_wr_en_o;
  logic [11:0] csr_wr_addr_o;
  logic [31:0] csr_wr_data_o;
  logic        hold_flag_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.RST_PC(RP)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .ecall_i(ecall_i), .ebreak_i(ebreak_i),
    .mret_i(mret_i), .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i),
    .jump_addr_i(jump_addr_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i), .csr_wr_en_o(csr_wr_en_o),
    .csr_wr_addr_o(csr_wr_addr_o), .csr_wr_data_o(csr_wr_data_o),
    .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  typedef struct {
    logic        rst, irq, ec, eb, mr;
    logic [31:0] inst;
    logic        jf;
    logic [31:0] ja, mst, mepc;
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic        hold, ia;
    logic [31:0] iaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic irq, input logic ec, input logic eb, input logic mr,
                     input logic [31:0] inst, input logic jf, input logic [31:0] ja,
                     input logic [31:0] mst, input logic [31:0] mepc,
                     input logic we, input logic [11:0] wa, input logic [31:0] wd,
                     input logic hold, input logic ia, input logic [31:0] iaddr);
    vec_t v;
    v.rst = r; v.irq = irq; v.ec = ec; v.eb = eb; v.mr = mr;
    v.inst = inst; v.jf = jf; v.ja = ja; v.mst = mst; v.mepc = mepc;
    v.we = we; v.wa = wa; v.wd = wd; v.hold = hold; v.ia = ia; v.iaddr = iaddr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst = 1'b0; irq_i = 1'b0; ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    jump_flag_i = 1'b0;
  endtask

  initial begin
    int lat;

    // rst irq ec eb mr  inst   jf ja     mst      mepc    | we wa     wd            hold ia iaddr
    add(1, 0, 1, 0, 0, 32'h100, 0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         0, 0, RP);     // reset wins
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         0, 0, RP);
    // ecall at 0x100
    add(0, 0, 1, 0, 0, 32'h100, 0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MEPC, 32'h100,       1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MST,  32'h80,        1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MCA,  32'd11,        1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 1, MTVEC);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         0, 0, RP);
    // ebreak at 0x20, an ecall arriving mid-sequence is ignored
    add(0, 0, 0, 1, 0, 32'h20,  0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 0, RP);
    add(0, 0, 1, 0, 0, 32'h999, 0, 32'h0, 32'h8, 32'h0,    1, A_MEPC, 32'h20,        1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MST,  32'h80,        1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MCA,  32'd3,         1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 1, MTVEC);
    // irq with a taken jump: mepc is the jump target
    add(0, 1, 0, 0, 0, 32'h50,  1, 32'h340, 32'h8, 32'h0,  0, 12'h0,  32'h0,         1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MEPC, 32'h340,       1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MST,  32'h80,        1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MCA,  32'h8000_000B, 1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 1, MTVEC);
    // irq masked by MIE=0, then taken once MIE rises
    add(0, 1, 0, 0, 0, 32'h60,  0, 32'h0, 32'h0, 32'h0,    0, 12'h0,  32'h0,         0, 0, RP);
    add(0, 1, 0, 0, 0, 32'h60,  0, 32'h0, 32'h0, 32'h0,    0, 12'h0,  32'h0,         0, 0, RP);
    add(0, 1, 0, 0, 0, 32'h60,  0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MEPC, 32'h60,        1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MST,  32'h80,        1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MCA,  32'h8000_000B, 1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 1, MTVEC);
    // mret with mstatus=0x80, mepc=0x104
    add(0, 0, 0, 0, 1, 32'h0,   0, 32'h0, 32'h80, 32'h104, 0, 12'h0,  32'h0,         1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h80, 32'h104, 1, A_MST,  32'h88,        1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h80, 32'h104, 0, 12'h0,  32'h0,         1, 1, 32'h104);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h80, 32'h104, 0, 12'h0,  32'h0,         0, 0, RP);
    // mret with MIE=1, MPIE=0 and other bits set
    add(0, 0, 0, 0, 1, 32'h0,   0, 32'h0, 32'h1808, 32'h44, 0, 12'h0, 32'h0,         1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h1808, 32'h44, 1, A_MST, 32'h1880,      1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h1808, 32'h44, 0, 12'h0, 32'h0,         1, 1, 32'h44);
    // ecall + mret + irq together: ecall only, held irq taken afterwards
    add(0, 1, 1, 0, 1, 32'h300, 0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 0, RP);
    add(0, 1, 0, 0, 0, 32'h300, 0, 32'h0, 32'h8, 32'h0,    1, A_MEPC, 32'h300,       1, 0, RP);
    add(0, 1, 0, 0, 0, 32'h300, 0, 32'h0, 32'h8, 32'h0,    1, A_MST,  32'h80,        1, 0, RP);
    add(0, 1, 0, 0, 0, 32'h300, 0, 32'h0, 32'h8, 32'h0,    1, A_MCA,  32'd11,        1, 0, RP);
    add(0, 1, 0, 0, 0, 32'h300, 0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 1, MTVEC);
    add(0, 1, 0, 0, 0, 32'h400, 0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MEPC, 32'h400,       1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MST,  32'h80,        1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MCA,  32'h8000_000B, 1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 1, MTVEC);
    // reset during W_MSTATUS abandons the sequence
    add(0, 0, 1, 0, 0, 32'h500, 0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         1, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    1, A_MEPC, 32'h500,       1, 0, RP);
    add(1, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         0, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         0, 0, RP);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h8, 32'h0,    0, 12'h0,  32'h0,         0, 0, RP);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; irq_i = vecs[i].irq; ecall_i = vecs[i].ec;
      ebreak_i = vecs[i].eb; mret_i = vecs[i].mr; inst_addr_i = vecs[i].inst;
      jump_flag_i = vecs[i].jf; jump_addr_i = vecs[i].ja;
      csr_mstatus_i = vecs[i].mst; csr_mepc_i = vecs[i].mepc;
      #2;
      check($sformatf("v%0d_wr_en", i),    {31'b0, csr_wr_en_o},  {31'b0, vecs[i].we});
      check($sformatf("v%0d_wr_addr", i),  {20'b0, csr_wr_addr_o}, {20'b0, vecs[i].wa});
      check($sformatf("v%0d_wr_data", i),  csr_wr_data_o,          vecs[i].wd);
      check($sformatf("v%0d_hold", i),     {31'b0, hold_flag_o},  {31'b0, vecs[i].hold});
      check($sformatf("v%0d_int_assert", i), {31'b0, int_assert_o}, {31'b0, vecs[i].ia});
      check($sformatf("v%0d_int_addr", i), int_addr_o,            vecs[i].iaddr);
      $display("vec %0d: we=%0b addr=%03h data=%08h hold=%0b ia=%0b iaddr=%08h",
               i, csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o, hold_flag_o, int_assert_o, int_addr_o);
    end

    // Trap latency: ecall pulse to int_assert_o, bounded wait.
    @(negedge clk);
    drive_idle();
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h0000_0A00;
    ecall_i = 1'b1; inst_addr_i = 32'h700;
    #2;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      drive_idle();
      #2;
      if (int_assert_o) begin
        lat = k;
        check("trap_target", int_addr_o, 32'h0000_0A00);
        break;
      end
    end
    check("trap_latency", lat, 32'd4);
    $display("trap latency %0d", lat);

    // mret latency, bounded wait.
    @(negedge clk);
    drive_idle();
    csr_mstatus_i = 32'h80; csr_mepc_i = 32'h0000_0104;
    mret_i = 1'b1;
    #2;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      drive_idle();
      #2;
      if (int_assert_o) begin
        lat = k;
        check("mret_target", int_addr_o, 32'h0000_0104);
        break;
      end
    end
    check("mret_latency", lat, 32'd2);
    $display("mret latency %0d", lat);

    // The redirect pulse lasts exactly one cycle.
    @(negedge clk);
    #2;
    check("mret_pulse_width", {31'b0, int_assert_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
